// File: rtl/xband_axis_frame_source.sv
// -----------------------------------------------------------------------------
// xband_axis_frame_source
//
// Built-in self-test frame generator for the Xband MM2S stream input. It
// stands in for the DMA: on a rising edge of `start` it emits one AXI-Stream
// frame of `byte_count` bytes carrying an incrementing, PRBS or constant
// pattern. It honours tready backpressure and marks the final beat with tlast
// and a partial tkeep.
//
// Parameters
//   POLY        Galois LFSR feedback mask used in PRBS mode
//   CONST_WORD  data word used in constant mode
//
// Ports
//   sys_clk        in   system clock
//   sys_rst        in   asynchronous, active-high reset
//   start          in   frame request, rising edge triggers (sys_clk synchronous)
//   byte_count     in   frame length in bytes, latched on the start edge
//   pattern_sel    in   0 = incrementing, 1 = PRBS, 2/3 = CONST_WORD
//   seed           in   initial PRBS state (0 is replaced by 1)
//   m_axis_tdata   out  stream data, lane 0 (bits 7:0) is the first byte
//   m_axis_tkeep   out  byte enables
//   m_axis_tlast   out  last beat of the frame
//   m_axis_tvalid  out  beat valid
//   m_axis_tready  in   sink ready
//   busy           out  frame in progress
//   done           out  one-cycle pulse after the last beat is accepted
//   start_miss     out  sticky: a start edge arrived while busy
//   frames_sent    out  completed frame count, wraps at 16 bits
// -----------------------------------------------------------------------------
module xband_axis_frame_source #(
  parameter logic [31:0] POLY       = 32'h80200003,
  parameter logic [31:0] CONST_WORD = 32'hA5A5A5A5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [31:0] byte_count,
  input  logic [1:0]  pattern_sel,
  input  logic [31:0] seed,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        done,
  output logic        start_miss,
  output logic [15:0] frames_sent
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // One Galois LFSR step: shift right, fold in the feedback mask when the
  // bit shifted out was set.
  function automatic logic [31:0] prbs_step(input logic [31:0] s);
    prbs_step = (s >> 1) ^ (s[0] ? POLY : 32'h0000_0000);
  endfunction

  // Byte enables for a beat; only the last beat can be partial.
  function automatic logic [3:0] keep_for(input logic is_last, input logic [1:0] rem);
    if (!is_last) begin
      keep_for = 4'b1111;
    end else begin
      case (rem)
        2'd0:    keep_for = 4'b1111;
        2'd1:    keep_for = 4'b0001;
        2'd2:    keep_for = 4'b0011;
        2'd3:    keep_for = 4'b0111;
        default: keep_for = 4'b1111;
      endcase
    end
  endfunction

  // Beat payload for the selected pattern. Lanes with a low keep bit are
  // forced to zero so the sink never sees stale bytes past the frame end.
  function automatic logic [31:0] beat_data(input logic [1:0]  pat,
                                            input logic [31:0] lfsr,
                                            input logic [7:0]  inc,
                                            input logic [3:0]  keep);
    logic [31:0] raw;
    case (pat)
      2'd0:    raw = {inc + 8'd3, inc + 8'd2, inc + 8'd1, inc};
      2'd1:    raw = lfsr;
      default: raw = CONST_WORD;
    endcase
    for (int i = 0; i < 4; i++) begin
      beat_data[8*i +: 8] = raw[8*i +: 8] & {8{keep[i]}};
    end
  endfunction

  // State and output registers
  state_t      state_q;
  logic        start_prev_q;
  logic [31:0] tdata_q;
  logic [3:0]  tkeep_q;
  logic        tlast_q;
  logic        tvalid_q;
  logic        busy_q;
  logic        done_q;
  logic        start_miss_q;
  logic [15:0] frames_q;

  // Latched frame configuration and per-beat generator state
  logic [29:0] n_q;          // index of the beat currently presented
  logic [29:0] last_idx_q;   // words - 1
  logic [1:0]  rem_q;        // byte_count[1:0]
  logic [1:0]  pat_q;
  logic [31:0] lfsr_q;       // PRBS state of the presented beat
  logic [7:0]  inc_q;        // lane-0 byte of the presented beat, (4n) mod 256

  // Candidate next-state values for launching beat 0 and advancing to beat n+1
  logic        start_edge_d;
  logic        beat_accept_d;
  logic [29:0] launch_last_idx_d;
  logic [31:0] launch_seed_d;
  logic        launch_is_last_d;
  logic [3:0]  launch_keep_d;
  logic [31:0] launch_data_d;
  logic [29:0] adv_n_d;
  logic [31:0] adv_lfsr_d;
  logic [7:0]  adv_inc_d;
  logic        adv_is_last_d;
  logic [3:0]  adv_keep_d;
  logic [31:0] adv_data_d;

  // Beat generation for the launch and advance paths
  always_comb begin
    start_edge_d  = start & ~start_prev_q;
    beat_accept_d = tvalid_q & m_axis_tready;

    // words - 1 = ceil(bc/4) - 1 = bc[31:2] - (bc[1:0] == 0). This form keeps
    // the full 32-bit range (0xFFFFFFFF -> 0x3FFFFFFF) without a wide adder.
    launch_last_idx_d = byte_count[31:2] - {29'd0, (byte_count[1:0] == 2'd0)};
    if (seed == 32'd0) begin
      launch_seed_d = 32'd1;
    end else begin
      launch_seed_d = seed;
    end
    launch_is_last_d = (launch_last_idx_d == 30'd0);
    launch_keep_d    = keep_for(launch_is_last_d, byte_count[1:0]);
    launch_data_d    = beat_data(pattern_sel, launch_seed_d, 8'd0, launch_keep_d);

    adv_n_d       = n_q + 30'd1;
    adv_lfsr_d    = prbs_step(lfsr_q);
    adv_inc_d     = inc_q + 8'd4;
    adv_is_last_d = (adv_n_d == last_idx_q);
    adv_keep_d    = keep_for(adv_is_last_d, rem_q);
    adv_data_d    = beat_data(pat_q, adv_lfsr_d, adv_inc_d, adv_keep_d);
  end

  // Frame FSM with registered stream and status outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      tdata_q      <= 32'd0;
      tkeep_q      <= 4'd0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_miss_q <= 1'b0;
      frames_q     <= 16'd0;
      n_q          <= 30'd0;
      last_idx_q   <= 30'd0;
      rem_q        <= 2'd0;
      pat_q        <= 2'd0;
      lfsr_q       <= 32'd0;
      inc_q        <= 8'd0;
    end else begin
      start_prev_q <= start;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A zero-length request is dropped without any side effect.
          if (start_edge_d && (byte_count != 32'd0)) begin
            state_q    <= ST_SEND;
            busy_q     <= 1'b1;
            tvalid_q   <= 1'b1;
            tdata_q    <= launch_data_d;
            tkeep_q    <= launch_keep_d;
            tlast_q    <= launch_is_last_d;
            n_q        <= 30'd0;
            last_idx_q <= launch_last_idx_d;
            rem_q      <= byte_count[1:0];
            pat_q      <= pattern_sel;
            lfsr_q     <= launch_seed_d;
            inc_q      <= 8'd0;
          end
        end
        ST_SEND: begin
          if (start_edge_d) begin
            start_miss_q <= 1'b1;
          end
          if (beat_accept_d) begin
            if (tlast_q) begin
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tdata_q  <= 32'd0;
              tkeep_q  <= 4'd0;
              done_q   <= 1'b1;
              frames_q <= frames_q + 16'd1;
            end else begin
              n_q     <= adv_n_d;
              lfsr_q  <= adv_lfsr_d;
              inc_q   <= adv_inc_d;
              tdata_q <= adv_data_d;
              tkeep_q <= adv_keep_d;
              tlast_q <= adv_is_last_d;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          tdata_q  <= 32'd0;
          tkeep_q  <= 4'd0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign start_miss    = start_miss_q;
  assign frames_sent   = frames_q;

endmodule

// File: tb/tb_xband_axis_frame_source.sv
// -----------------------------------------------------------------------------
// tb_xband_axis_frame_source
//
// Self-checking bench for xband_axis_frame_source: a table of short frames
// with hand-computed beats, plus directed sequences for PRBS with random
// backpressure, stalls, missed starts, zero length, reset mid-frame and
// back-to-back frames.
// -----------------------------------------------------------------------------
module tb_xband_axis_frame_source;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic [31:0] byte_count;
  logic [1:0]  pattern_sel;
  logic [31:0] seed;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        busy;
  logic        done;
  logic        start_miss;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  xband_axis_frame_source dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .start         (start),
    .byte_count    (byte_count),
    .pattern_sel   (pattern_sel),
    .seed          (seed),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .start_miss    (start_miss),
    .frames_sent   (frames_sent)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] bc;
    logic [1:0]  pat;
    logic [31:0] sd;
    int          nbeats;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  k_last;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_ref(input logic [31:0] s);
    lfsr_ref = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] inc_word(input int b);
    logic [7:0] x;
    x = 8'(4 * b);
    inc_word = {x + 8'd3, x + 8'd2, x + 8'd1, x};
  endfunction

  // Leaves the caller at the negedge where beat 0 should be visible.
  task automatic start_frame(input logic [31:0] bc, input logic [1:0] pat, input logic [31:0] sd);
    @(negedge sys_clk);
    byte_count  = bc;
    pattern_sel = pat;
    seed        = sd;
    start       = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] model;
    logic [31:0] prev_data;
    logic        have_prev;
    int          beat;
    int          cyc;
    logic [31:0] exp_d;

    vecs[0] = '{32'd9,  2'd0, 32'h0,        3, 32'h03020100, 32'h07060504, 32'h00000008, 4'b0001};
    vecs[1] = '{32'd4,  2'd0, 32'h0,        1, 32'h03020100, 32'h0,        32'h0,        4'b1111};
    vecs[2] = '{32'd7,  2'd2, 32'h0,        2, 32'hA5A5A5A5, 32'h00A5A5A5, 32'h0,        4'b0111};
    vecs[3] = '{32'd3,  2'd1, 32'h12345678, 1, 32'h00345678, 32'h0,        32'h0,        4'b0111};
    vecs[4] = '{32'd8,  2'd1, 32'h0,        2, 32'h00000001, 32'h80200003, 32'h0,        4'b1111};
    vecs[5] = '{32'd10, 2'd3, 32'h0,        3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0000A5A5, 4'b0011};
    vecs[6] = '{32'd12, 2'd0, 32'h0,        3, 32'h03020100, 32'h07060504, 32'h0B0A0908, 4'b1111};
    vecs[7] = '{32'd2,  2'd1, 32'h3,        1, 32'h00000003, 32'h0,        32'h0,        4'b0011};

    sys_rst       = 1'b1;
    start         = 1'b0;
    byte_count    = 32'd0;
    pattern_sel   = 2'd0;
    seed          = 32'd0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Reset state
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tkeep", {28'd0, m_axis_tkeep}, 32'd0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_miss", {31'd0, start_miss}, 32'd0);
    chk("rst_frames", {16'd0, frames_sent}, 32'd0);

    // Table of short frames, tready always high
    for (int v = 0; v < NV; v++) begin
      m_axis_tready = 1'b1;
      start_frame(vecs[v].bc, vecs[v].pat, vecs[v].sd);
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        exp_d = (b == 0) ? vecs[v].d0 : ((b == 1) ? vecs[v].d1 : vecs[v].d2);
        chk($sformatf("v%0d_b%0d_tvalid", v, b), {31'd0, m_axis_tvalid}, 32'd1);
        chk($sformatf("v%0d_b%0d_busy", v, b), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_b%0d_tdata", v, b), m_axis_tdata, exp_d);
        chk($sformatf("v%0d_b%0d_tkeep", v, b), {28'd0, m_axis_tkeep},
            {28'd0, (b == vecs[v].nbeats - 1) ? vecs[v].k_last : 4'b1111});
        chk($sformatf("v%0d_b%0d_tlast", v, b), {31'd0, m_axis_tlast},
            {31'd0, (b == vecs[v].nbeats - 1)});
        @(negedge sys_clk);
      end
      exp_frames++;
      chk($sformatf("v%0d_done", v), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_end_tvalid", v), {31'd0, m_axis_tvalid}, 32'd0);
      chk($sformatf("v%0d_end_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_frames", v), {16'd0, frames_sent}, exp_frames);
      @(negedge sys_clk);
      chk($sformatf("v%0d_done_clr", v), {31'd0, done}, 32'd0);
    end

    // Zero-length start is ignored
    start_frame(32'd0, 2'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("zero_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("zero_busy", {31'd0, busy}, 32'd0);
      chk("zero_done", {31'd0, done}, 32'd0);
      @(negedge sys_clk);
    end
    chk("zero_frames", {16'd0, frames_sent}, exp_frames);

    // Constant pattern, 6 bytes, tready low for 5 cycles after start
    m_axis_tready = 1'b0;
    start_frame(32'd6, 2'd2, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      chk("stall_tdata", m_axis_tdata, 32'hA5A5A5A5);
      chk("stall_tlast", {31'd0, m_axis_tlast}, 32'd0);
      @(negedge sys_clk);
    end
    m_axis_tready = 1'b1;
    chk("stall_b0_tdata", m_axis_tdata, 32'hA5A5A5A5);
    @(negedge sys_clk);
    chk("stall_b1_tdata", m_axis_tdata, 32'h0000A5A5);
    chk("stall_b1_tkeep", {28'd0, m_axis_tkeep}, 32'h3);
    chk("stall_b1_tlast", {31'd0, m_axis_tlast}, 32'd1);
    @(negedge sys_clk);
    exp_frames++;
    chk("stall_done", {31'd0, done}, 32'd1);
    chk("stall_frames", {16'd0, frames_sent}, exp_frames);

    // PRBS, 1024 bytes, seed 1, random backpressure
    m_axis_tready = 1'b1;
    start_frame(32'd1024, 2'd1, 32'd1);
    model     = 32'd1;
    beat      = 0;
    cyc       = 0;
    have_prev = 1'b0;
    prev_data = 32'd0;
    while (beat < 256 && cyc < 3000) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      chk("prbs_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      if (have_prev) begin
        chk("prbs_stable", m_axis_tdata, prev_data);
      end
      chk($sformatf("prbs_b%0d_tdata", beat), m_axis_tdata, model);
      chk("prbs_tkeep", {28'd0, m_axis_tkeep}, 32'hF);
      chk($sformatf("prbs_b%0d_tlast", beat), {31'd0, m_axis_tlast}, {31'd0, (beat == 255)});
      if (beat == 0) begin
        chk("prbs_beat0", m_axis_tdata, 32'h00000001);
      end
      if (beat == 1) begin
        chk("prbs_beat1", m_axis_tdata, 32'h80200003);
      end
      if (m_axis_tready) begin
        model     = lfsr_ref(model);
        beat      = beat + 1;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev_data = m_axis_tdata;
      end
      @(negedge sys_clk);
      cyc++;
    end
    chk("prbs_beats_accepted", beat, 32'd256);
    exp_frames++;
    chk("prbs_done", {31'd0, done}, 32'd1);
    chk("prbs_frames", {16'd0, frames_sent}, exp_frames);
    m_axis_tready = 1'b1;

    // Second start edge during a 64-byte frame
    chk("miss_before", {31'd0, start_miss}, 32'd0);
    start_frame(32'd64, 2'd0, 32'd0);
    for (int b = 0; b < 16; b++) begin
      chk("miss_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
      chk($sformatf("miss_b%0d_tdata", b), m_axis_tdata, inc_word(b));
      chk($sformatf("miss_b%0d_tlast", b), {31'd0, m_axis_tlast}, {31'd0, (b == 15)});
      start = (b == 5);
      @(negedge sys_clk);
    end
    start = 1'b0;
    exp_frames++;
    chk("miss_done", {31'd0, done}, 32'd1);
    chk("miss_flag", {31'd0, start_miss}, 32'd1);
    chk("miss_frames", {16'd0, frames_sent}, exp_frames);
    @(negedge sys_clk);
    chk("miss_no_relaunch", {31'd0, m_axis_tvalid}, 32'd0);
    chk("miss_sticky", {31'd0, start_miss}, 32'd1);

    // Reset on beat 3 of a 40-byte frame
    start_frame(32'd40, 2'd0, 32'd0);
    repeat (3) @(negedge sys_clk);
    chk("rstmid_b3_tdata", m_axis_tdata, 32'h0F0E0D0C);
    sys_rst = 1'b1;
    #1;
    chk("rstmid_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rstmid_tdata", m_axis_tdata, 32'd0);
    chk("rstmid_tkeep", {28'd0, m_axis_tkeep}, 32'd0);
    chk("rstmid_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_miss", {31'd0, start_miss}, 32'd0);
    chk("rstmid_frames", {16'd0, frames_sent}, 32'd0);
    @(negedge sys_clk);
    sys_rst    = 1'b0;
    exp_frames = 0;
    @(negedge sys_clk);
    chk("rstmid_not_resumed", {31'd0, m_axis_tvalid}, 32'd0);
    start_frame(32'd4, 2'd0, 32'd0);
    chk("post_tdata", m_axis_tdata, 32'h03020100);
    chk("post_tkeep", {28'd0, m_axis_tkeep}, 32'hF);
    chk("post_tlast", {31'd0, m_axis_tlast}, 32'd1);
    @(negedge sys_clk);
    exp_frames++;
    chk("post_done", {31'd0, done}, 32'd1);
    chk("post_frames", {16'd0, frames_sent}, exp_frames);

    // Back-to-back: start edge in the done cycle
    byte_count  = 32'd8;
    pattern_sel = 2'd2;
    start       = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    chk("b2b_done_clr", {31'd0, done}, 32'd0);
    chk("b2b_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    chk("b2b_b0_tdata", m_axis_tdata, 32'hA5A5A5A5);
    chk("b2b_b0_tlast", {31'd0, m_axis_tlast}, 32'd0);
    @(negedge sys_clk);
    chk("b2b_b1_tlast", {31'd0, m_axis_tlast}, 32'd1);
    chk("b2b_b1_tkeep", {28'd0, m_axis_tkeep}, 32'hF);
    @(negedge sys_clk);
    exp_frames++;
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_frames", {16'd0, frames_sent}, exp_frames);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xband_axis_frame_source.md
# xband_axis_frame_source

AXI-Stream frame generator in the sys_clk domain that acts as the initiator for the Xband MM2S stream input, replacing the DMA for built-in self-test. On a start request it emits one frame of a programmable byte length carrying a deterministic pattern (incrementing bytes, PRBS or constant), honouring tready backpressure. It marks the final beat with tlast and a partial tkeep so the TX buffer, the 8b10b link and the S2MM checker path can be exercised end to end.

## Interface
- POLY, 32'h80200003, Galois LFSR feedback mask for PRBS mode
- CONST_WORD, 32'hA5A5A5A5, data word for constant mode
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- start  in  1  frame request; rising edge (start & ~start_d) triggers a frame
- byte_count  in  32  frame length in bytes; latched on the start edge
- pattern_sel  in  2  0 = incrementing, 1 = PRBS, 2/3 = CONST_WORD; latched on the start edge
- seed  in  32  initial PRBS state; latched on the start edge; value 0 is replaced by 1
- m_axis_tdata  out  32  stream data; byte lane 0 = tdata[7:0] is the first byte
- m_axis_tkeep  out  4  byte enables
- m_axis_tlast  out  1  last beat of the frame
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last beat is accepted
- start_miss  out  1  sticky flag: a start edge arrived while busy
- frames_sent  out  16  count of completed frames; wraps from 0xFFFF to 0

## Operation
- FSM has two states: IDLE and SEND. All outputs are registered.
- IDLE: a start edge with byte_count != 0 latches the configuration and sets words = ceil(byte_count/4) and rem = byte_count[1:0]. It loads beat n = 0, sets the state to SEND, and sets busy = 1 and tvalid = 1.
- IDLE: a start edge with byte_count == 0 is ignored. No beat is sent, done is not pulsed and the counters are unchanged.
- SEND: a beat is accepted on any cycle with tvalid & tready. On acceptance, n increments and the next beat is presented on the following cycle, so throughput is one beat per cycle.
- While a beat is not accepted, tvalid, tdata, tkeep and tlast stay stable.
- Beat n data:
  - Incrementing: lane i = (4n+i) mod 256.
  - PRBS: tdata = LFSR state. The LFSR starts at the seed and advances once per accepted beat: next = (s>>1) ^ (s[0] ? POLY : 0).
  - Constant: tdata = CONST_WORD.
- tlast = 1 only when n == words-1.
- tkeep = 4'b1111 on every beat except the last. On the last beat, tkeep depends on rem: 0 gives 1111, 1 gives 0001, 2 gives 0011, 3 gives 0111.
- Byte lanes whose tkeep bit is low are driven 0.
- Last beat accepted: the state returns to IDLE, and on the next cycle tvalid = 0, tlast = 0, busy = 0, done = 1 and frames_sent increments.
- Start edge while busy: ignored; start_miss is set and stays set until sys_rst.
- byte_count, pattern_sel and seed changes during SEND have no effect.
- The beat counter is 30 bits wide, so byte_count up to 0xFFFFFFFF is supported (words = 0x40000000).

## Timing
- Reset values: tdata = 0, tkeep = 0, tlast = 0, tvalid = 0, busy = 0, done = 0, start_miss = 0, frames_sent = 0, and start_d = 0. The FSM resets to IDLE.
- sys_rst asserted mid-frame: tvalid drops immediately (asynchronous) and the frame is abandoned. It is not resumed after reset.
- Latency: a start edge sampled at posedge k gives tvalid = 1 with beat 0 after posedge k.
- Back-to-back frames: a start edge sampled in the cycle where done = 1 launches the next frame, and that frame's tvalid rises on the same edge that clears done. The minimum gap between frames is therefore one idle cycle.
- The block never deasserts tvalid without a handshake, except on sys_rst.
- start must be synchronous to sys_clk. It is the caller's responsibility to synchronise it.

## Test plan
- byte_count = 9, pattern 0, tready = 1: three consecutive beats.
  - Beat 0: 0x03020100, tkeep 1111.
  - Beat 1: 0x07060504, tkeep 1111.
  - Beat 2: 0x00000008, tkeep 0001, tlast = 1.
  - done pulses one cycle after beat 2 and frames_sent = 1.
- byte_count = 1024, pattern 1, seed = 1, tready random at 50 %: 256 beats.
  - Beat 0 = 0x00000001 and beat 1 = 0x80200003.
  - The remaining beats match the reference LFSR model.
  - Data is held stable across every stalled cycle, and tlast appears only on beat 255.
- byte_count = 6, pattern 2, tready low for 5 cycles after start: beat 0 = 0xA5A5A5A5 held for 5 cycles, then beat 1 = 0x0000A5A5 with tkeep 0011 and tlast = 1.
- Second start edge during a 64-byte frame: the frame completes normally with 16 beats, start_miss = 1 and frames_sent increments by exactly 1.
- byte_count = 0 start: tvalid, busy and done stay 0, and frames_sent is unchanged.
- sys_rst pulse on beat 3 of a 40-byte frame:
  - All outputs return to their reset values immediately.
  - A new start with byte_count = 4 then sends one beat 0x03020100, tkeep 1111, tlast = 1.
